// File: rtl/step_two.sv
// SHA-256 message padder: packs a byte stream into 512-bit blocks, appends 0x80, zero fill
// and the 64-bit big-endian bit length, and hands each block downstream with valid/ready.
module step_two #(
   parameter int unsigned LEN_BYTES_W = 61
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [7:0]  i_data,
   input  logic        i_valid,
   input  logic        i_last,
   output logic        o_ready,
   output logic [31:0] o_w0,
   output logic [31:0] o_w1,
   output logic [31:0] o_w2,
   output logic [31:0] o_w3,
   output logic [31:0] o_w4,
   output logic [31:0] o_w5,
   output logic [31:0] o_w6,
   output logic [31:0] o_w7,
   output logic [31:0] o_w8,
   output logic [31:0] o_w9,
   output logic [31:0] o_w10,
   output logic [31:0] o_w11,
   output logic [31:0] o_w12,
   output logic [31:0] o_w13,
   output logic [31:0] o_w14,
   output logic [31:0] o_w15,
   output logic        o_block_valid,
   input  logic        i_block_ready,
   output logic        o_block_first,
   output logic        o_block_last
);

   typedef enum logic [1:0] {StFill, StPad, StLen, StEmit} state_e;

   state_e                 state_q, state_d;
   logic [511:0]           blk_q, blk_d;
   logic [5:0]             ptr_q, ptr_d;
   logic [LEN_BYTES_W-1:0] cnt_q, cnt_d;
   logic                   pad_pend_q, pad_pend_d;
   logic                   len_pend_q, len_pend_d;
   logic                   first_q, first_d;
   logic                   last_q, last_d;

   logic [8:0]  byte_lsb;
   logic [63:0] len_bits;

   // Byte n of the block lives at bits [511-8n -: 8], i.e. LSB at 504-8n.
   assign byte_lsb = 9'd504 - {ptr_q, 3'b000};
   assign len_bits = 64'({cnt_q, 3'b000});

   always_comb begin
      state_d       = state_q;
      blk_d         = blk_q;
      ptr_d         = ptr_q;
      cnt_d         = cnt_q;
      pad_pend_d    = pad_pend_q;
      len_pend_d    = len_pend_q;
      first_d       = first_q;
      last_d        = last_q;
      o_ready       = 1'b0;
      o_block_valid = 1'b0;

      unique case (state_q)
         StFill: begin
            o_ready = 1'b1;
            if (i_valid) begin
               blk_d[byte_lsb +: 8] = i_data;
               ptr_d = ptr_q + 6'd1;
               cnt_d = cnt_q + LEN_BYTES_W'(1);
               if (ptr_q == 6'd63) begin
                  state_d    = StEmit;
                  pad_pend_d = i_last;
               end else if (i_last) begin
                  state_d = StPad;
               end
            end
         end
         StPad: begin
            blk_d[byte_lsb +: 8] = 8'h80;
            if (ptr_q <= 6'd55) begin
               state_d = StLen;
            end else begin
               // No room for the length field: it goes into an extra block.
               state_d    = StEmit;
               len_pend_d = 1'b1;
            end
         end
         StLen: begin
            blk_d[63:0] = len_bits;
            last_d      = 1'b1;
            state_d     = StEmit;
         end
         StEmit: begin
            o_block_valid = 1'b1;
            if (i_block_ready) begin
               blk_d   = '0;
               ptr_d   = '0;
               first_d = last_q;
               if (last_q) begin
                  cnt_d  = '0;
                  last_d = 1'b0;
               end
               if (pad_pend_q) begin
                  state_d    = StPad;
                  pad_pend_d = 1'b0;
               end else if (len_pend_q) begin
                  state_d    = StLen;
                  len_pend_d = 1'b0;
               end else begin
                  state_d = StFill;
               end
            end
         end
         default: state_d = StFill;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= StFill;
         blk_q      <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         pad_pend_q <= 1'b0;
         len_pend_q <= 1'b0;
         first_q    <= 1'b1;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         blk_q      <= blk_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         pad_pend_q <= pad_pend_d;
         len_pend_q <= len_pend_d;
         first_q    <= first_d;
         last_q     <= last_d;
      end
   end

   assign o_block_first = first_q;
   assign o_block_last  = last_q;

   assign o_w0  = blk_q[511:480];
   assign o_w1  = blk_q[479:448];
   assign o_w2  = blk_q[447:416];
   assign o_w3  = blk_q[415:384];
   assign o_w4  = blk_q[383:352];
   assign o_w5  = blk_q[351:320];
   assign o_w6  = blk_q[319:288];
   assign o_w7  = blk_q[287:256];
   assign o_w8  = blk_q[255:224];
   assign o_w9  = blk_q[223:192];
   assign o_w10 = blk_q[191:160];
   assign o_w11 = blk_q[159:128];
   assign o_w12 = blk_q[127:96];
   assign o_w13 = blk_q[95:64];
   assign o_w14 = blk_q[63:32];
   assign o_w15 = blk_q[31:0];

endmodule
